// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out shift register with a load
// handshake. Words are emitted MSB first, one bit per enabled clock, and
// back-to-back frames run without bubble cycles.
// Optional feature macro: PISO_PARITY_EN appends an even-parity bit to
// every frame, so each frame is width+1 bits long.
module piso_serializer #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [width-1:0] din,
  input  logic             en,
  output logic             q,
  output logic             q_valid,
  output logic             last,
  output logic             done
);

  localparam int CW = $clog2(width + 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           state_reg;
  logic [width-1:0] shreg_reg;
  logic [width-1:0] shift_next;
  logic [CW-1:0]    cnt_reg;
  logic             done_reg;
  logic             final_bit;
  logic             accept;
`ifdef PISO_PARITY_EN
  logic             par_reg;
`endif

  // Left-shift path: each bit takes its lower neighbour, a zero enters at bit 0.
  assign shift_next[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < width; gi++) begin : g_shift
      assign shift_next[gi] = shreg_reg[gi-1];
    end
  endgenerate

  // Serial-side outputs; everything is forced low while reset is asserted.
  always_comb begin
    q_valid   = rst && (state_reg != IDLE) && en;
    q         = 1'b0;
    final_bit = 1'b0;
    if (rst) begin
      case (state_reg)
        SHIFT: q = shreg_reg[width-1];
`ifdef PISO_PARITY_EN
        PARITY: q = par_reg;
`endif
        default: q = 1'b0;
      endcase
    end
`ifdef PISO_PARITY_EN
    // The parity bit closes the frame, so the last data bit is not final.
    final_bit = q_valid && (state_reg == PARITY);
`else
    final_bit = q_valid && (state_reg == SHIFT) && (cnt_reg == CW'(1));
`endif
  end

  assign last       = final_bit;
  // A new word may be taken while idle or on the closing bit of a frame.
  assign load_ready = rst && ((state_reg == IDLE) || final_bit);
  assign accept     = load_valid && load_ready;
  assign done       = rst && done_reg;

  // Frame sequencing: load, shift per enabled cycle, optional parity, reload.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      shreg_reg <= '0;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_reg   <= 1'b0;
`endif
    end else begin
      done_reg <= final_bit;
      if (accept) begin
        // Loading overrides the shift/return path on the closing bit.
        state_reg <= SHIFT;
        shreg_reg <= din;
        cnt_reg   <= CW'(width);
`ifdef PISO_PARITY_EN
        par_reg   <= ^din;
`endif
      end else begin
        case (state_reg)
          SHIFT: begin
            if (en) begin
              shreg_reg <= shift_next;
              cnt_reg   <= cnt_reg - CW'(1);
              if (cnt_reg == CW'(1)) begin
`ifdef PISO_PARITY_EN
                state_reg <= PARITY;
`else
                state_reg <= IDLE;
`endif
              end
            end
          end
`ifdef PISO_PARITY_EN
          PARITY: begin
            if (en) begin
              state_reg <= IDLE;
            end
          end
`endif
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out shift register with a load handshake. It is the transmit-side counterpart of the catalog's serial-in, left-shifting register.
- Accepts a width-bit word and emits it MSB-first, one bit per enabled clock.
- A left-shifting serial-in register on the far end, fed the same bit stream, reconstructs the original word.
- Used for serial links between catalog blocks and as a test source for the serial-in register.

Parameters:
- width, 8, word length in bits; legal range width >= 2

Ports:
- clk  input  1  clock; all logic on posedge
- rst  input  1  synchronous active-low reset
- load_valid  input  1  din holds a word to transmit
- load_ready  output  1  block accepts a word this cycle
- din  input  width  parallel word to serialize
- en  input  1  shift enable; when low, the block holds all state
- q  output  1  serial data bit, MSB first
- q_valid  output  1  q is a valid bit consumed this cycle
- last  output  1  q carries the final bit of the frame
- done  output  1  one-cycle pulse the cycle after the final bit is consumed

Behaviour:
- Reset:
  - Clock and reset: one clock (clk); rst is synchronous and active-low.
  - While rst=0 at a posedge: state to IDLE; shreg, cnt, parity register and done cleared.
  - While rst=0, outputs are forced: q=0, q_valid=0, last=0, load_ready=0, done=0.
  - First cycle after rst=1: load_ready=1.
- Registers:
  - shreg[width-1:0].
  - cnt, $clog2(width+1) bits.
  - state: IDLE, SHIFT, plus PARITY when the option is compiled in.
  - done flop.
- q = shreg[width-1] in SHIFT; q = 0 in IDLE.
- q_valid = (state != IDLE) && en. A bit is consumed only in a cycle where q_valid=1.
- IDLE:
  - load_ready=1.
  - On load_valid=1: shreg <= din, cnt <= width, next state SHIFT. The first bit appears the next cycle.
- SHIFT with en=1:
  - shreg <= {shreg[width-2:0],1'b0}; cnt <= cnt-1.
  - When cnt==1, the cycle is the final data bit; go to IDLE, or to PARITY if the option is compiled in.
- SHIFT with en=0: shreg, cnt and state hold; q holds its value; q_valid=0.
- last = q_valid on the final output cycle (the cnt==1 data bit, or the parity bit when enabled).
- load_ready:
  - Also high on the final output cycle with en=1. A load accepted there goes directly to SHIFT with the new word.
  - Back-to-back frames therefore have zero bubble cycles.
- load_valid while load_ready=0 is ignored; din is not sampled.
- done:
  - Registered; 1 for exactly one cycle after any cycle with last=1.
  - Pulses even if a new frame was loaded back-to-back.
- Reset mid-frame: frame aborted, no done pulse, remaining bits discarded; the next load starts a fresh frame.
- Latency: load handshake at cycle N -> first bit valid at N+1 (if en=1) -> last bit at N+width with en held high.

Optional Feature:
- Macro: PISO_PARITY_EN
- Defined:
  - On load, register par <= ^din (even parity).
  - After the final data bit, enter PARITY for one enabled cycle with q = par.
  - last moves to the parity cycle, not the final data bit; frame length is width+1 bits.
  - en=0 in PARITY holds the state.
  - load_ready is high on the parity cycle with en=1.
- Undefined: no PARITY state or par register; frame length is width bits.

Test Plan:
- Reset: rst=0 for 2 cycles with load_valid=1 -> q=0, q_valid=0, load_ready=0, done=0; after rst=1 -> load_ready=1 and nothing shifted until load.
- Single frame: width=8, load 8'hA5, en=1 -> q = 1,0,1,0,0,1,0,1 on 8 consecutive q_valid cycles; last on the 8th; done=1 the next cycle only.
- Stall:
  - Load 8'hC3; drop en for 3 cycles after 2 bits are consumed.
  - q holds at 0 with q_valid=0 during the stall; bits 0,0,0,0,1,1 follow.
  - last arrives 11 cycles after the load.
- Back-to-back: load_valid held high with din 8'hFF then 8'h00 -> 16 contiguous q_valid cycles (8 ones, 8 zeros); load_ready pulses on both final bits; done pulses twice.
- Ignore/abort:
  - load_valid=1 with 8'h55 mid-frame -> ignored; the original word completes.
  - rst=0 after 4 bits -> q_valid=0, no done pulse; a following load of 8'h81 serializes correctly.
- PISO_PARITY_EN: load 8'h07 -> 9th bit 1 with last=1; load 8'h03 -> 9th bit 0; done after the 9th bit.
